// File: rtl/gfx_fb_arbiter.sv
// Framebuffer arbiter: merges pattern-generator writes and display reads into one registered SRAM command stream.
// Optional writer starvation guard enabled by defining FB_ARB_STARVE_GUARD_EN.
module gfx_fb_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 20,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned RD_BURST_MAX = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_data_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_we,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic                  m_rdata_valid,
  input  logic [DATA_WIDTH-1:0] m_rdata
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state, state_nxt;
  logic                  we_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [DATA_WIDTH-1:0] wdata_nxt;
  logic                  can_accept;
  logic                  sel_wr;
  logic                  sel_rd;
  logic                  starved;

`ifdef FB_ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = $clog2(RD_BURST_MAX + 1);

  logic [CNT_W-1:0] streak, streak_nxt;

  // Reads granted back-to-back while the writer waits; saturates at the limit because the writer then wins.
  assign starved = (streak == CNT_W'(RD_BURST_MAX));

  always_comb begin
    streak_nxt = streak;
    if (wr_ready || !wr_valid) begin
      streak_nxt = '0;
    end else if (rd_ready) begin
      streak_nxt = streak + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      streak <= '0;
    end else begin
      streak <= streak_nxt;
    end
  end
`else
  assign starved = 1'b0;
`endif

  // The command slot frees up when idle or when the held command is taken this cycle.
  assign can_accept = !reset && ((state == IDLE) || m_ready);
  assign sel_wr     = wr_valid && (!rd_valid || starved);
  assign sel_rd     = rd_valid && !sel_wr;
  assign wr_ready   = can_accept && sel_wr;
  assign rd_ready   = can_accept && sel_rd;

  assign m_valid       = (state == BUSY);
  assign rd_data_valid = m_rdata_valid;
  assign rd_data       = m_rdata;

  always_comb begin
    state_nxt = state;
    we_nxt    = m_we;
    addr_nxt  = m_addr;
    wdata_nxt = m_wdata;

    case (state)
      IDLE:    if (wr_ready || rd_ready) state_nxt = BUSY;
      BUSY:    if (m_ready && !(wr_ready || rd_ready)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if (wr_ready) begin
      we_nxt    = 1'b1;
      addr_nxt  = wr_addr;
      wdata_nxt = wr_data;
    end else if (rd_ready) begin
      we_nxt    = 1'b0;
      addr_nxt  = rd_addr;
      wdata_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
    end else begin
      state   <= state_nxt;
      m_we    <= we_nxt;
      m_addr  <= addr_nxt;
      m_wdata <= wdata_nxt;
    end
  end

endmodule

// File: doc/gfx_fb_arbiter.md
GFX_FB_ARBITER -- requirements
Module: gfx_fb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 20, meaning framebuffer word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, meaning framebuffer word (pixel) width.
REQ-003 SHALL have parameter RD_BURST_MAX, default 8, meaning maximum consecutive read grants while a write waits.
REQ-004 SHALL have ports: clk input 1, single clock; reset input 1, synchronous active-high reset.
REQ-005 SHALL have ports: wr_valid input 1, wr_ready output 1, wr_addr input ADDR_WIDTH, wr_data input DATA_WIDTH; pattern-generator write request.
REQ-006 SHALL have ports: rd_valid input 1, rd_ready output 1, rd_addr input ADDR_WIDTH; display prefetch read request.
REQ-007 SHALL have ports: rd_data_valid output 1, rd_data output DATA_WIDTH; read response to the display.
REQ-008 SHALL have ports: m_valid output 1, m_ready input 1, m_we output 1, m_addr output ADDR_WIDTH, m_wdata output DATA_WIDTH; command to the SRAM controller.
REQ-009 SHALL have ports: m_rdata_valid input 1, m_rdata input DATA_WIDTH; read data from the SRAM controller.

Function
REQ-010 SHALL implement states IDLE (no registered command) and BUSY (m_valid=1, command held stable).
REQ-011 SHALL accept a request (valid & ready) only when state is IDLE, or BUSY with m_ready=1 in the same cycle.
REQ-012 SHALL assert at most one of wr_ready/rd_ready per cycle, combinationally, to the selected requester only.
REQ-013 SHALL select the reader when both valid, unless the starvation guard (REQ-022) selects the writer.
REQ-014 SHALL register the accepted request into m_we/m_addr/m_wdata and raise m_valid the cycle after acceptance (1-cycle latency).
REQ-015 SHALL hold m_we, m_addr, m_wdata constant while m_valid=1 and m_ready=0.
REQ-016 SHALL transition BUSY->IDLE on m_ready=1 with no request accepted; stay BUSY when a new request is accepted that cycle (one command per cycle sustained).
REQ-017 SHALL drive m_wdata to 0 for read commands.
REQ-018 SHALL pass m_rdata_valid/m_rdata to rd_data_valid/rd_data combinationally, zero latency, in order.
REQ-019 SHALL not alter or drop requests: every accepted request yields exactly one m_valid&m_ready handshake.

Reset
REQ-020 SHALL on reset=1 at posedge clk enter IDLE, clear m_valid, m_we, m_addr, m_wdata to 0 and the read-streak counter to 0.
REQ-021 SHALL drive wr_ready=0 and rd_ready=0 while reset=1; a command pending mid-operation is discarded.

Configuration
REQ-022 With FB_ARB_STARVE_GUARD_EN defined, SHALL keep a read-streak counter ($clog2(RD_BURST_MAX+1) bits): increments on each read acceptance while wr_valid=1, clears on write acceptance or when wr_valid=0; when counter==RD_BURST_MAX and wr_valid=1 the writer is selected over the reader.
REQ-023 Without FB_ARB_STARVE_GUARD_EN, SHALL use strict read priority with no counter; writer may starve indefinitely.

Verification
REQ-024 Bench: reset, wr_valid=1 addr=0x00010 data=0x0ABC, m_ready=1 -> wr_ready=1 cycle N, m_valid=1 m_we=1 m_addr=0x00010 m_wdata=0x0ABC cycle N+1.
REQ-025 Bench: rd_valid and wr_valid both held high, m_ready=1, guard enabled -> 8 read commands, then 1 write, then 8 reads; guard disabled -> reads only.
REQ-026 Bench: read addr=0x12345 accepted, m_ready=0 for 5 cycles -> m_valid/m_addr stable 5 cycles, rd_ready=wr_ready=0, then accepted on m_ready=1.
REQ-027 Bench: m_ready=1 continuously, 100 alternating requests -> 100 m_valid handshakes in 101 cycles, order preserved.
REQ-028 Bench: reset asserted while BUSY with m_ready=0 -> next cycle m_valid=0, state IDLE, no handshake emitted.
REQ-029 Bench: m_rdata_valid=1 m_rdata=0x0F0F -> rd_data_valid=1 rd_data=0x0F0F same cycle.
